tone_sequencer: RTL and testbench

- Controller for the team's clockDivider (divisor input 20 bits; reset input held high to silence).
- Plays a programmed sequence of (divisor, duration) steps, e.g. buzzer melodies.
- Drives the divider's divisor and reset in step with an internal millisecond-scale tick.
- Sits between a register/CPU write interface and one clockDivider instance.

---
 rtl/tone_seq_pkg.sv | 21 ++
 rtl/tone_sequencer_tick_prescaler.sv | 37 +++
 rtl/tone_sequencer.sv | 172 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_seq_pkg.sv
// Shared types and default widths for the tone sequencer.
// Pure declarations: no logic, no latency.
// Step entries pair a divisor (0 = rest) with a duration in ticks (0 = skip).
package tone_seq_pkg;

   localparam int DEPTH_DEF = 16;
   localparam int DIV_W_DEF = 20;
   localparam int DUR_W_DEF = 12;

   typedef struct packed {
      logic [DIV_W_DEF-1:0] divisor;
      logic [DUR_W_DEF-1:0] duration;
   } step_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      PLAY  = 2'd2
   } state_t;

endpackage

// File: rtl/tone_sequencer_tick_prescaler.sv
// Free-running modulo-TICK_CYCLES counter; tick marks the wrap cycle.
// Latency: tick is decoded combinationally from the counter register.
// No backpressure; clr forces the count back to zero on the next edge.
module tick_prescaler #(
   parameter int TICK_CYCLES = 50000,
   localparam int CNT_W = $clog2(TICK_CYCLES)
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   // Next count: clear on request, wrap at LAST, otherwise increment.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tone_sequencer.sv
// Plays a table of (divisor, duration) steps into a clockDivider.
// Latency: busy one edge after start; first tone one edge later; 1-cycle FETCH gap between steps.
// No backpressure; stop aborts from any state, start while busy is ignored.
module tone_sequencer
   import tone_seq_pkg::*;
#(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 1000,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DUR_W   = DUR_W_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DIV_W-1:0]  wr_divisor,
   input  logic [DUR_W-1:0]  wr_duration,
   input  logic [ADDR_W:0]   length,
   input  logic              loop,
   input  logic              start,
   input  logic              stop,
   output logic [DIV_W-1:0]  divisor,
   output logic              div_reset,
   output logic [ADDR_W-1:0] step_idx,
   output logic              busy,
   output logic              done
);

   localparam int TICK_CYCLES = CLK_HZ / TICK_HZ;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   step_t             table_q [DEPTH];
   step_t             rd_q;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              loop_q, loop_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic [DIV_W-1:0]  divisor_q, divisor_d;
   logic              div_reset_q, div_reset_d;
   logic [ADDR_W-1:0] step_idx_q, step_idx_d;
   logic              done_q, done_d;
   logic              advance;
   logic              last_step;
   logic              tick;

   tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_prescaler (
      .clock (clock),
      .reset (reset),
      .clr   (state_q != PLAY),
      .tick  (tick)
   );

   assign last_step = ({1'b0, idx_q} == (len_q - (ADDR_W + 1)'(1)));

   // Step table: writes only while idle; read addressed by the next index so
   // the entry for idx_q is already registered when FETCH evaluates it.
   always_ff @(posedge clock) begin
      if (wr_en && (state_q == IDLE)) begin
         table_q[wr_addr] <= '{divisor: wr_divisor, duration: wr_duration};
      end
      rd_q <= table_q[idx_d];
   end

   // Next-state, step advance and output decisions; stop overrides everything.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      loop_d      = loop_q;
      dur_d       = dur_q;
      divisor_d   = divisor_q;
      div_reset_d = div_reset_q;
      step_idx_d  = step_idx_q;
      done_d      = 1'b0;
      advance     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (length == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = FETCH;
                  idx_d   = '0;
                  len_d   = (length > DEPTH_L) ? DEPTH_L : length;
                  loop_d  = loop;
               end
            end
         end
         FETCH: begin
            dur_d = '0;
            if (rd_q.duration == '0) begin
               advance = 1'b1;
            end else begin
               state_d     = PLAY;
               divisor_d   = rd_q.divisor;
               div_reset_d = (rd_q.divisor == '0);
               step_idx_d  = idx_q;
            end
         end
         PLAY: begin
            if (tick) begin
               if (dur_q == (rd_q.duration - DUR_W'(1))) begin
                  advance = 1'b1;
               end else begin
                  dur_d = dur_q + DUR_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (advance) begin
         if (!last_step) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FETCH;
         end else if (loop_q) begin
            idx_d   = '0;
            state_d = FETCH;
         end else begin
            state_d     = IDLE;
            done_d      = 1'b1;
            divisor_d   = '0;
            div_reset_d = 1'b1;
         end
      end

      if (stop) begin
         state_d     = IDLE;
         done_d      = 1'b0;
         divisor_d   = '0;
         div_reset_d = 1'b1;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         len_q       <= '0;
         loop_q      <= 1'b0;
         dur_q       <= '0;
         divisor_q   <= '0;
         div_reset_q <= 1'b1;
         step_idx_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         loop_q      <= loop_d;
         dur_q       <= dur_d;
         divisor_q   <= divisor_d;
         div_reset_q <= div_reset_d;
         step_idx_q  <= step_idx_d;
         done_q      <= done_d;
      end
   end

   assign divisor   = divisor_q;
   assign div_reset = div_reset_q;
   assign step_idx  = step_idx_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: segment tables of expected outputs per cycle.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// All expectations are hand-derived constants.
module tb_tone_sequencer;

   localparam int DEPTH  = 4;
   localparam int DIV_W  = 20;
   localparam int DUR_W  = 12;
   localparam int ADDR_W = 2;

   logic              clock;
   logic              reset;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DIV_W-1:0]  wr_divisor;
   logic [DUR_W-1:0]  wr_duration;
   logic [ADDR_W:0]   length;
   logic              loop;
   logic              start;
   logic              stop;
   logic [DIV_W-1:0]  divisor;
   logic              div_reset;
   logic [ADDR_W-1:0] step_idx;
   logic              busy;
   logic              done;

   int checks   = 0;
   int failures = 0;

   // One record = n consecutive cycles with identical expected outputs.
   typedef struct {
      int                n;
      logic              busy;
      logic              done;
      logic [DIV_W-1:0]  div;
      logic              dr;
      logic [ADDR_W-1:0] idx;
      logic              chk_idx;
   } seg_t;

   seg_t segs[$];

   tone_sequencer #(
      .CLK_HZ  (1000),
      .TICK_HZ (100),
      .DEPTH   (DEPTH),
      .DIV_W   (DIV_W),
      .DUR_W   (DUR_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_divisor  (wr_divisor),
      .wr_duration (wr_duration),
      .length      (length),
      .loop        (loop),
      .start       (start),
      .stop        (stop),
      .divisor     (divisor),
      .div_reset   (div_reset),
      .step_idx    (step_idx),
      .busy        (busy),
      .done        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic seg_t sg(int n, logic b, logic d, logic [DIV_W-1:0] dv,
                               logic dr, logic [ADDR_W-1:0] ix, logic ci);
      seg_t s;
      s.n = n; s.busy = b; s.done = d; s.div = dv; s.dr = dr; s.idx = ix; s.chk_idx = ci;
      return s;
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic run_segs(input string name);
      for (int s = 0; s < segs.size(); s++) begin
         for (int k = 0; k < segs[s].n; k++) begin
            checks++;
            if (busy !== segs[s].busy || done !== segs[s].done || divisor !== segs[s].div ||
                div_reset !== segs[s].dr || (segs[s].chk_idx && step_idx !== segs[s].idx)) begin
               failures++;
               $display("FAIL %s seg%0d cyc%0d: got busy=%b done=%b div=%0d dr=%b idx=%0d, expected busy=%b done=%b div=%0d dr=%b idx=%0d",
                        name, s, k, busy, done, divisor, div_reset, step_idx,
                        segs[s].busy, segs[s].done, segs[s].div, segs[s].dr, segs[s].idx);
            end
            cyc();
         end
      end
      segs.delete();
   endtask

   task automatic write_step(input int addr, input int dv, input int du);
      wr_en       = 1'b1;
      wr_addr     = ADDR_W'(addr);
      wr_divisor  = DIV_W'(dv);
      wr_duration = DUR_W'(du);
      cyc();
      wr_en = 1'b0;
   endtask

   // Pulse start for one edge; returns at the sample point of the FETCH cycle.
   task automatic kick(input int len, input logic lp);
      length = (ADDR_W + 1)'(len);
      loop   = lp;
      start  = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_divisor = '0; wr_duration = '0;
      length = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
      #12;
      chk("rst_divisor", divisor, 0);
      chk("rst_div_reset", div_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_step_idx", step_idx, 0);
      #2 reset = 1'b0;
      cyc();

      // Basic three-step sequence with a rest in the middle.
      write_step(0, 100, 2);
      write_step(1, 0, 1);
      write_step(2, 250, 3);
      kick(3, 1'b0);
      segs.push_back(sg(1, 1, 0, 0, 1, 0, 0));
      segs.push_back(sg(20, 1, 0, 100, 0, 0, 1));
      segs.push_back(sg(1, 1, 0, 100, 0, 0, 1));
      segs.push_back(sg(10, 1, 0, 0, 1, 1, 1));
      segs.push_back(sg(1, 1, 0, 0, 1, 1, 1));
      segs.push_back(sg(30, 1, 0, 250, 0, 2, 1));
      segs.push_back(sg(1, 0, 1, 0, 1, 0, 0));
      segs.push_back(sg(3, 0, 0, 0, 1, 0, 0));
      run_segs("basic");

      // Looping with a zero-duration step: two-cycle gap, tone held.
      write_step(0, 50, 1);
      write_step(1, 70, 0);
      kick(2, 1'b1);
      segs.push_back(sg(1, 1, 0, 0, 1, 0, 0));
      for (int r = 0; r < 3; r++) begin
         segs.push_back(sg(10, 1, 0, 50, 0, 0, 1));
         segs.push_back(sg(2, 1, 0, 50, 0, 0, 1));
      end
      run_segs("skip_loop");
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      chk("stop_divisor", divisor, 0);
      chk("stop_div_reset", div_reset, 1);
      cyc();
      chk("stop_done_after", done, 0);

      // Start and stop together in IDLE.
      length = 3'd1; start = 1'b1; stop = 1'b1;
      cyc();
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", busy, 0);
      cyc();
      chk("startstop_busy2", busy, 0);
      chk("startstop_done", done, 0);

      // Start re-asserted on the 5th PLAY cycle must not restart.
      write_step(0, 30, 2);
      kick(1, 1'b0);
      cyc();
      repeat (4) cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      segs.push_back(sg(15, 1, 0, 30, 0, 0, 1));
      segs.push_back(sg(1, 0, 1, 0, 1, 0, 0));
      segs.push_back(sg(2, 0, 0, 0, 1, 0, 0));
      run_segs("start_busy");

      // length = 0: done one cycle later, stays silent.
      length = '0; start = 1'b1;
      cyc();
      start = 1'b0;
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 0);
      chk("len0_div_reset", div_reset, 1);
      cyc();
      chk("len0_done_after", done, 0);

      // length = 7 clamps to DEPTH = 4 steps.
      for (int i = 0; i < 4; i++) write_step(i, 11 + i, 1);
      kick(7, 1'b0);
      segs.push_back(sg(1, 1, 0, 0, 1, 0, 0));
      for (int i = 0; i < 4; i++) begin
         segs.push_back(sg(10, 1, 0, DIV_W'(11 + i), 0, ADDR_W'(i), 1));
         if (i < 3) segs.push_back(sg(1, 1, 0, DIV_W'(11 + i), 0, ADDR_W'(i), 1));
      end
      segs.push_back(sg(1, 0, 1, 0, 1, 0, 0));
      segs.push_back(sg(2, 0, 0, 0, 1, 0, 0));
      run_segs("clamp");

      // Write during PLAY is ignored, in this play and on a replay.
      kick(2, 1'b0);
      cyc();
      wr_en = 1'b1; wr_addr = 2'd1; wr_divisor = 20'd99; wr_duration = 12'd3;
      cyc();
      wr_en = 1'b0;
      segs.push_back(sg(9, 1, 0, 11, 0, 0, 1));
      segs.push_back(sg(1, 1, 0, 11, 0, 0, 1));
      segs.push_back(sg(10, 1, 0, 12, 0, 1, 1));
      segs.push_back(sg(1, 0, 1, 0, 1, 0, 0));
      segs.push_back(sg(1, 0, 0, 0, 1, 0, 0));
      run_segs("wr_busy");
      kick(2, 1'b0);
      segs.push_back(sg(1, 1, 0, 0, 1, 0, 0));
      segs.push_back(sg(10, 1, 0, 11, 0, 0, 1));
      segs.push_back(sg(1, 1, 0, 11, 0, 0, 1));
      segs.push_back(sg(10, 1, 0, 12, 0, 1, 1));
      segs.push_back(sg(1, 0, 1, 0, 1, 0, 0));
      run_segs("replay");

      // Maximum duration step.
      write_step(0, 1, 4095);
      kick(1, 1'b0);
      segs.push_back(sg(1, 1, 0, 0, 1, 0, 0));
      segs.push_back(sg(40950, 1, 0, 1, 0, 0, 1));
      segs.push_back(sg(1, 0, 1, 0, 1, 0, 0));
      run_segs("max_dur");

      // Asynchronous reset in the middle of PLAY.
      kick(1, 1'b0);
      repeat (5) cyc();
      chk("pre_reset_divisor", divisor, 1);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_divisor", divisor, 0);
      chk("async_rst_div_reset", div_reset, 1);
      chk("async_rst_busy", busy, 0);
      #2 reset = 1'b0;
      cyc();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_divisor", divisor, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
